fetch_stage_btb: RTL and testbench

//  IF stage of the 5-stage RV32I pipeline: PC register, direct-mapped BTB with 2-bit

---
 rtl/fetch_stage_btb.sv | 141 ++++++++++++++
 tb/tb_fetch_stage_btb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_btb.sv
// IF stage: PC register, direct-mapped BTB with 2-bit direction counters,
// and the IF/ID pipeline register.
module fetch_stage_btb #(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        if_id_en,
  input  logic        if_id_flush,
  input  logic        modify_pc_ex,
  input  logic [31:0] pc_target_ex,
  input  logic        btb_upd_en,
  input  logic [31:0] btb_upd_pc,
  input  logic        btb_upd_taken,
  input  logic [31:0] btb_upd_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_tgt,
  output logic        if_id_valid
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Counter encoding: 00 SNT, 01 WNT, 10 ST, 11 WT; MSB is the prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b10;
  localparam logic [1:0] CTR_WT  = 2'b11;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [31:0] pc;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             pred_taken;
  logic [31:0]      pred_next;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  logic unused_upd_low;

  // Step a direction counter toward the resolved outcome.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    logic [1:0] n;
    n = c;
    if (taken) begin
      case (c)
        CTR_SNT: n = CTR_WNT;
        CTR_WNT: n = CTR_WT;
        CTR_WT:  n = CTR_ST;
        default: n = CTR_ST;
      endcase
    end else begin
      case (c)
        CTR_ST:  n = CTR_WT;
        CTR_WT:  n = CTR_WNT;
        CTR_WNT: n = CTR_SNT;
        default: n = CTR_SNT;
      endcase
    end
    return n;
  endfunction

  assign imem_addr      = pc;
  assign unused_upd_low = ^btb_upd_pc[1:0];

  // BTB lookup on the current PC, reading pre-update contents.
  always_comb begin
    lk_idx     = pc[IDX_W+1:2];
    lk_tag     = pc[31:IDX_W+2];
    lk_hit     = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    pred_taken = lk_hit && btb_ctr[lk_idx][1];
    pred_next  = pred_taken ? btb_target[lk_idx] : pc + 32'd4;
  end

  // Hit detection for the EX training port.
  always_comb begin
    up_idx = btb_upd_pc[IDX_W+1:2];
    up_tag = btb_upd_pc[31:IDX_W+2];
    up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
  end

  // PC register: EX redirect beats a hazard hold.
  always_ff @(posedge clk) begin
    if (rst)               pc <= RESET_PC;
    else if (modify_pc_ex) pc <= pc_target_ex;
    else if (pc_en)        pc <= pred_next;
  end

  // IF/ID register: flush inserts a NOP bubble.
  always_ff @(posedge clk) begin
    if (rst || if_id_flush) begin
      if_id_instr      <= NOP_INSTR;
      if_id_pc         <= 32'h0;
      if_id_pred_taken <= 1'b0;
      if_id_pred_tgt   <= 32'h0;
      if_id_valid      <= 1'b0;
    end else if (if_id_en) begin
      if_id_instr      <= imem_rdata;
      if_id_pc         <= pc;
      if_id_pred_taken <= pred_taken;
      if_id_pred_tgt   <= pred_next;
      if_id_valid      <= 1'b1;
    end
  end

  // BTB valid bits: allocate on a taken miss.
  always_ff @(posedge clk) begin
    if (rst)                                          btb_valid <= '0;
    else if (btb_upd_en && !up_hit && btb_upd_taken) btb_valid[up_idx] <= 1'b1;
  end

  // BTB payload: train on hit, fill on taken miss.
  always_ff @(posedge clk) begin
    if (!rst && btb_upd_en) begin
      if (up_hit) begin
        btb_ctr[up_idx] <= ctr_step(btb_ctr[up_idx], btb_upd_taken);
        if (btb_upd_taken) btb_target[up_idx] <= btb_upd_target;
      end else if (btb_upd_taken) begin
        btb_tag[up_idx]    <= up_tag;
        btb_target[up_idx] <= btb_upd_target;
        btb_ctr[up_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage_btb.sv
// Bench for fetch_stage_btb: directed scenarios then random traffic,
// all checked against a behavioural model of the fetch stage.
module tb_fetch_stage_btb;

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;

  logic        clk = 1'b0;
  logic        rst, pc_en, if_id_en, if_id_flush, modify_pc_ex;
  logic [31:0] pc_target_ex;
  logic        btb_upd_en, btb_upd_taken;
  logic [31:0] btb_upd_pc, btb_upd_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc, if_id_pred_tgt;
  logic        if_id_pred_taken, if_id_valid;

  int total = 0;
  int bad   = 0;

  // Model state: fetch PC, IF/ID contents, BTB as slots holding full PCs.
  logic [31:0] m_pc, m_instr, m_ipc, m_itgt;
  logic        m_ipt, m_iv;
  bit          mv   [N];
  logic [31:0] mown [N];
  logic [31:0] mtgt [N];
  int          mlev [N];   // 0 strong NT, 1 weak NT, 2 weak T, 3 strong T

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage_btb #(.BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .modify_pc_ex(modify_pc_ex),
    .pc_target_ex(pc_target_ex), .btb_upd_en(btb_upd_en),
    .btb_upd_pc(btb_upd_pc), .btb_upd_taken(btb_upd_taken),
    .btb_upd_target(btb_upd_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pred_taken(if_id_pred_taken), .if_id_pred_tgt(if_id_pred_tgt),
    .if_id_valid(if_id_valid)
  );

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 32'(N));
  endfunction

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return (a >> (2 + IW)) == (b >> (2 + IW));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_tick();
    int          s;
    bit          hit, pt;
    logic [31:0] pn, npc;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_ipc = 32'h0; m_ipt = 1'b0; m_itgt = 32'h0; m_iv = 1'b0;
      for (int i = 0; i < int'(N); i++) mv[i] = 1'b0;
      return;
    end
    s   = slot(m_pc);
    hit = mv[s] && same_line(mown[s], m_pc);
    pt  = hit && (mlev[s] >= 2);
    pn  = pt ? mtgt[s] : m_pc + 32'd4;
    if (modify_pc_ex) npc = pc_target_ex;
    else if (!pc_en)  npc = m_pc;
    else              npc = pn;
    if (if_id_flush) begin
      m_instr = 32'h13; m_ipc = 32'h0; m_ipt = 1'b0; m_itgt = 32'h0; m_iv = 1'b0;
    end else if (if_id_en) begin
      m_instr = mem_word(m_pc); m_ipc = m_pc; m_ipt = pt; m_itgt = pn; m_iv = 1'b1;
    end
    if (btb_upd_en) begin
      s = slot(btb_upd_pc);
      if (mv[s] && same_line(mown[s], btb_upd_pc)) begin
        if (btb_upd_taken) begin
          mlev[s] = (mlev[s] < 3) ? mlev[s] + 1 : 3;
          mtgt[s] = btb_upd_target;
        end else begin
          mlev[s] = (mlev[s] > 0) ? mlev[s] - 1 : 0;
        end
      end else if (btb_upd_taken) begin
        mv[s] = 1'b1; mown[s] = btb_upd_pc; mtgt[s] = btb_upd_target; mlev[s] = 2;
      end
    end
    m_pc = npc;
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_id_instr", if_id_instr, m_instr);
    chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_pred_taken", 32'(if_id_pred_taken), 32'(m_ipt));
    chk("if_id_pred_tgt", if_id_pred_tgt, m_itgt);
    chk("if_id_valid", 32'(if_id_valid), 32'(m_iv));
  endtask

  task automatic tick();
    model_tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ctl(input logic r, input logic pe, input logic ie, input logic fl,
                     input logic mod, input logic [31:0] tgt);
    rst = r; pc_en = pe; if_id_en = ie; if_id_flush = fl; modify_pc_ex = mod; pc_target_ex = tgt;
  endtask

  task automatic upd(input logic en, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    btb_upd_en = en; btb_upd_pc = pc; btb_upd_taken = tk; btb_upd_target = tgt;
  endtask

  // Redirect to a PC for one cycle, then run one normal fetch cycle from it.
  task automatic fetch_from(input logic [31:0] a);
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a);
    tick();
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) return $urandom;
    a = (32'($urandom_range(0, 15)) << 2) | (($urandom_range(0, 1) != 0) ? 32'h40 : 32'h0);
    return a;
  endfunction

  initial begin
    ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    upd(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset held two cycles.
    tick();
    tick();
    chk("reset_pc", imem_addr, 32'h0);
    chk("reset_instr", if_id_instr, 32'h13);
    chk("reset_valid", 32'(if_id_valid), 32'h0);

    // Sequential fetch 0,4,8,...
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("seq_first_pc", if_id_pc, 32'h0);
    tick(); tick(); tick();
    chk("seq_pc", imem_addr, 32'h10);

    // Stall three cycles at 0x10.
    ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick(); tick();
    chk("stall_pc", imem_addr, 32'h10);
    chk("stall_ifid_pc", if_id_pc, 32'hC);

    // Train 0x20 taken -> 0x100, fetch it.
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    upd(1'b1, 32'h20, 1'b1, 32'h100);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_from(32'h20);
    chk("train_next_pc", imem_addr, 32'h100);
    chk("train_pred_taken", 32'(if_id_pred_taken), 32'h1);
    chk("train_pred_tgt", if_id_pred_tgt, 32'h100);

    // Second taken then one not-taken: still predicts taken.
    upd(1'b1, 32'h20, 1'b1, 32'h100);
    tick();
    upd(1'b1, 32'h20, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_from(32'h20);
    chk("one_nt_pc", imem_addr, 32'h100);

    // Second not-taken: falls through.
    upd(1'b1, 32'h20, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_from(32'h20);
    chk("two_nt_pc", imem_addr, 32'h24);
    chk("two_nt_pred", 32'(if_id_pred_taken), 32'h0);

    // Same-cycle lookup and update of 0x20: lookup sees old counter.
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
    tick();
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    upd(1'b1, 32'h20, 1'b1, 32'h180);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    chk("same_cycle_pc", imem_addr, 32'h24);
    fetch_from(32'h20);
    chk("after_update_pc", imem_addr, 32'h180);

    // Redirect overriding a PC hold, with flush.
    ctl(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    tick();
    chk("redir_pc", imem_addr, 32'h200);
    chk("redir_valid", 32'(if_id_valid), 32'h0);
    chk("redir_instr", if_id_instr, 32'h13);

    // Alias: 0x60 shares 0x20's slot and replaces it.
    ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    upd(1'b1, 32'h20 + 4 * N, 1'b1, 32'h400);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0);
    fetch_from(32'h20);
    chk("alias_old_miss", imem_addr, 32'h24);
    fetch_from(32'h20 + 4 * N);
    chk("alias_new_hit", imem_addr, 32'h400);

    // PC wraps past the top of the address space.
    fetch_from(32'hFFFF_FFFC);
    chk("wrap_pc", imem_addr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      ctl(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), pick_addr());
      upd(($urandom_range(0, 1) != 0), pick_addr(), ($urandom_range(0, 1) != 0), pick_addr());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
